aoi22_pipe: RTL and testbench



---
 rtl/aoi22_pipe_pkg.sv | 18 +
 rtl/aoi22_pipe_chk.sv | 15 +
 rtl/aoi22_pipe_stage.sv | 39 +++
 rtl/aoi22_pipe.sv | 89 ++++++++
 tb/tb_aoi22_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aoi22_pipe_pkg.sv
// Shared constants and the width-generic AOI22 helper for the aoi22_pipe block.
package aoi22_pipe_pkg;

  localparam int AOI22_PIPE_MAX_STAGES = 4;
  localparam int AOI22_PIPE_MAX_WIDTH  = 64;
  localparam int AOI22_PIPE_CNT_W      = 16;

  typedef logic [AOI22_PIPE_MAX_WIDTH-1:0] aoi22_word_t;

  // Callers zero-extend narrower operands and truncate the result back.
  function automatic aoi22_word_t aoi22_f(input aoi22_word_t a1,
                                          input aoi22_word_t a2,
                                          input aoi22_word_t b1,
                                          input aoi22_word_t b2);
    return ~((a1 & a2) | (b1 & b2));
  endfunction

endpackage

// File: rtl/aoi22_pipe_chk.sv
// Protocol checker for aoi22_pipe: a stalled output must hold valid and data.
module aoi22_pipe_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] zn
);

  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(zn)));

endmodule

// File: rtl/aoi22_pipe_stage.sv
// One elastic register slot: valid bit plus WIDTH data, loading whenever it is
// empty or its downstream neighbour is ready.
module aoi22_pipe_stage
  import aoi22_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             load_s;

  assign load_s = ~valid_r | dn_ready;

  // Slot register; an empty load clears valid but keeps the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
    end else if (load_s) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= up_data;
      end
    end
  end

  assign dn_valid = valid_r;
  assign dn_data  = data_r;

endmodule

// File: rtl/aoi22_pipe.sv
// Registered, back-pressured WIDTH-bit AOI22 pipeline of STAGES elastic slots.
// Define AOI22_PIPE_PERF_EN to add saturating XFER_CNT / STALL_CNT outputs.
module aoi22_pipe
  import aoi22_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            A1,
  input  logic [WIDTH-1:0]            A2,
  input  logic [WIDTH-1:0]            B1,
  input  logic [WIDTH-1:0]            B2,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [WIDTH-1:0]            ZN,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY
`ifdef AOI22_PIPE_PERF_EN
  ,
  output logic [AOI22_PIPE_CNT_W-1:0] XFER_CNT,
  output logic [AOI22_PIPE_CNT_W-1:0] STALL_CNT
`endif
);

  if ((WIDTH < 1) || (WIDTH > AOI22_PIPE_MAX_WIDTH)) begin : g_bad_width
    $error("aoi22_pipe: WIDTH out of range 1..64");
  end
  if ((STAGES < 1) || (STAGES > AOI22_PIPE_MAX_STAGES)) begin : g_bad_stages
    $error("aoi22_pipe: STAGES out of range 1..4");
  end

  // Index k is the input side of stage k; index STAGES is the pipeline output.
  logic [STAGES:0]  up_valid_s;
  logic [STAGES:0]  ready_s;
  logic [WIDTH-1:0] data_s [STAGES+1];

  assign up_valid_s[0] = IN_VALID;
  assign data_s[0]     = WIDTH'(aoi22_f(AOI22_PIPE_MAX_WIDTH'(A1), AOI22_PIPE_MAX_WIDTH'(A2),
                                        AOI22_PIPE_MAX_WIDTH'(B1), AOI22_PIPE_MAX_WIDTH'(B2)));
  assign ready_s[STAGES] = OUT_READY;

  // Ready is unrolled into "some slot at or after k is empty, or the sink takes".
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign ready_s[k] = OUT_READY | ~(&up_valid_s[STAGES:k+1]);

    aoi22_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .up_valid (up_valid_s[k]),
      .up_data  (data_s[k]),
      .dn_ready (ready_s[k+1]),
      .dn_valid (up_valid_s[k+1]),
      .dn_data  (data_s[k+1])
    );
  end

  assign IN_READY  = ready_s[0] & ~RST;
  assign OUT_VALID = up_valid_s[STAGES];
  assign ZN        = data_s[STAGES];

`ifdef AOI22_PIPE_PERF_EN
  localparam logic [AOI22_PIPE_CNT_W-1:0] CNT_MAX = {AOI22_PIPE_CNT_W{1'b1}};
  localparam logic [AOI22_PIPE_CNT_W-1:0] CNT_ONE = AOI22_PIPE_CNT_W'(1);

  logic [AOI22_PIPE_CNT_W-1:0] xfer_cnt_r;
  logic [AOI22_PIPE_CNT_W-1:0] stall_cnt_r;

  // Saturating counters of output transfers and output stall cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      xfer_cnt_r  <= {AOI22_PIPE_CNT_W{1'b0}};
      stall_cnt_r <= {AOI22_PIPE_CNT_W{1'b0}};
    end else begin
      if (OUT_VALID && OUT_READY && (xfer_cnt_r != CNT_MAX)) begin
        xfer_cnt_r <= xfer_cnt_r + CNT_ONE;
      end
      if (OUT_VALID && !OUT_READY && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
    end
  end

  assign XFER_CNT  = xfer_cnt_r;
  assign STALL_CNT = stall_cnt_r;
`endif

endmodule

// File: tb/tb_aoi22_pipe.sv
// Scoreboard bench for aoi22_pipe: main 8-bit/2-stage instance plus 1-bit/1-stage
// and 64-bit/4-stage instances for the truth-table and latency sweep.
module tb_aoi22_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] a1, a2, b1, b2, zn;
  logic in_valid, in_ready, out_valid, out_ready;

  logic sa_a1, sa_a2, sa_b1, sa_b2, sa_zn, sa_iv, sa_ir, sa_ov;
  logic [63:0] sb_a1, sb_a2, sb_b1, sb_b2, sb_zn;
  logic sb_iv, sb_ir, sb_ov;
  logic small_or;

`ifdef AOI22_PIPE_PERF_EN
  logic [15:0] xfer_cnt, stall_cnt, sa_xc, sa_sc, sb_xc, sb_sc;
`endif

  aoi22_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .B1(b1), .B2(b2),
    .IN_VALID(in_valid), .IN_READY(in_ready), .ZN(zn),
    .OUT_VALID(out_valid), .OUT_READY(out_ready)
`ifdef AOI22_PIPE_PERF_EN
    , .XFER_CNT(xfer_cnt), .STALL_CNT(stall_cnt)
`endif
  );

  aoi22_pipe #(.WIDTH(1), .STAGES(1)) dut_sa (
    .CLK(clk), .RST(rst), .A1(sa_a1), .A2(sa_a2), .B1(sa_b1), .B2(sa_b2),
    .IN_VALID(sa_iv), .IN_READY(sa_ir), .ZN(sa_zn),
    .OUT_VALID(sa_ov), .OUT_READY(small_or)
`ifdef AOI22_PIPE_PERF_EN
    , .XFER_CNT(sa_xc), .STALL_CNT(sa_sc)
`endif
  );

  aoi22_pipe #(.WIDTH(64), .STAGES(4)) dut_sb (
    .CLK(clk), .RST(rst), .A1(sb_a1), .A2(sb_a2), .B1(sb_b1), .B2(sb_b2),
    .IN_VALID(sb_iv), .IN_READY(sb_ir), .ZN(sb_zn),
    .OUT_VALID(sb_ov), .OUT_READY(small_or)
`ifdef AOI22_PIPE_PERF_EN
    , .XFER_CNT(sb_xc), .STALL_CNT(sb_sc)
`endif
  );

  aoi22_pipe_chk #(.WIDTH(W)) u_chk (
    .clk(clk), .rst(rst), .out_valid(out_valid), .out_ready(out_ready), .zn(zn)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  logic [W-1:0] exp_q[$], got_q[$];
  int in_cyc_q[$], out_cyc_q[$];
  logic sa_exp_q[$], sa_got_q[$];
  int sa_in_q[$], sa_out_q[$];
  logic [63:0] sb_exp_q[$], sb_got_q[$];
  int sb_in_q[$], sb_out_q[$];

  function automatic logic [63:0] ref_aoi(input logic [63:0] p, input logic [63:0] q,
                                          input logic [63:0] r, input logic [63:0] s);
    ref_aoi = ~((p & q) | (r & s));
  endfunction

  // Record accepted operands (as expected results) and produced results.
  always @(posedge clk) begin
    cyc_n = cyc_n + 1;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(W'(ref_aoi(64'(a1), 64'(a2), 64'(b1), 64'(b2))));
        in_cyc_q.push_back(cyc_n);
      end
      if (out_valid && out_ready) begin
        got_q.push_back(zn);
        out_cyc_q.push_back(cyc_n);
      end
      if (sa_iv && sa_ir) begin
        sa_exp_q.push_back(1'(ref_aoi(64'(sa_a1), 64'(sa_a2), 64'(sa_b1), 64'(sa_b2))));
        sa_in_q.push_back(cyc_n);
      end
      if (sa_ov && small_or) begin
        sa_got_q.push_back(sa_zn);
        sa_out_q.push_back(cyc_n);
      end
      if (sb_iv && sb_ir) begin
        sb_exp_q.push_back(ref_aoi(sb_a1, sb_a2, sb_b1, sb_b2));
        sb_in_q.push_back(cyc_n);
      end
      if (sb_ov && small_or) begin
        sb_got_q.push_back(sb_zn);
        sb_out_q.push_back(cyc_n);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); in_cyc_q.delete(); out_cyc_q.delete();
    sa_exp_q.delete(); sa_got_q.delete(); sa_in_q.delete(); sa_out_q.delete();
    sb_exp_q.delete(); sb_got_q.delete(); sb_in_q.delete(); sb_out_q.delete();
  endtask

  task automatic rand_ops();
    a1 = W'($urandom); a2 = W'($urandom); b1 = W'($urandom); b2 = W'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a1 = '0; a2 = '0; b1 = '0; b2 = '0;
    sa_iv = 1'b0; sb_iv = 1'b0; small_or = 1'b0;
    sa_a1 = 1'b0; sa_a2 = 1'b0; sa_b1 = 1'b0; sa_b2 = 1'b0;
    sb_a1 = '0; sb_a2 = '0; sb_b1 = '0; sb_b2 = '0;
    #2; cyc(); cyc();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (zn !== 8'h00) begin n_fail++; $display("FAIL reset_zn: got %h expected 00", zn); end
    rst = 1'b0; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_rel: got %b expected 1", in_ready); end
    clear_sb();
  endtask

  task automatic test_single();
    clear_sb();
    out_ready = 1'b1;
    a1 = 8'hF0; a2 = 8'hFF; b1 = 8'h0F; b2 = 8'h03; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    cyc();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_tests++; if (zn !== 8'h0C) begin n_fail++; $display("FAIL single_zn: got %h expected 0c", zn); end
    cyc();
    n_tests++;
    if (got_q.size() != 1 || in_cyc_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d outputs expected 1", got_q.size());
    end else if (out_cyc_q[0] - in_cyc_q[0] != S) begin
      n_fail++; $display("FAIL single_latency: got %0d expected %0d", out_cyc_q[0] - in_cyc_q[0], S);
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    int gaps = 0;
    clear_sb();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      if (in_ready !== 1'b1) drops++;
      cyc();
    end
    in_valid = 1'b0;
    repeat (S + 2) cyc();
    n_tests++; if (drops != 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d low cycles expected 0", drops); end
    n_tests++;
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 16", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        if (i > 0 && out_cyc_q[i] - out_cyc_q[i-1] != 1) gaps++;
      end
      n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_consecutive: got %0d gaps expected 0", gaps); end
    end
  endtask

  task automatic test_full_stall();
    int acc = 0;
    clear_sb();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      if (in_ready === 1'b1) acc++;
      cyc();
    end
    n_tests++; if (acc != S) begin n_fail++; $display("FAIL full_accepts: got %0d expected %0d", acc, S); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (exp_q.size() == 0 || out_valid !== 1'b1 || zn !== exp_q[0]) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b zn=%h", i, out_valid, zn);
      end
      cyc();
    end
    rand_ops(); out_ready = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_drain_ready: got %b expected 1", in_ready); end
    cyc();
    n_tests++;
    if (got_q.size() != 1 || exp_q.size() != S + 1) begin
      n_fail++; $display("FAIL fill_drain_same_cycle: got out=%0d in=%0d expected 1 and %0d", got_q.size(), exp_q.size(), S + 1);
    end
    in_valid = 1'b0;
    repeat (S + 2) cyc();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_sb();
    out_ready = 1'b1; in_valid = 1'b1;
    rand_ops(); cyc();
    rand_ops(); cyc();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b1; #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    n_tests++; if (zn !== 8'h00) begin n_fail++; $display("FAIL midrst_zn: got %h expected 00", zn); end
    cyc();
    #2 rst = 1'b0;
    clear_sb();
    cyc();
    rand_ops(); in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (S + 3) cyc();
    n_tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_count: got %0d expected 1", got_q.size());
    end else begin
      n_tests++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midrst_data: got %h expected %h", got_q[0], exp_q[0]); end
      n_tests++; if (out_cyc_q[0] - in_cyc_q[0] != S) begin n_fail++; $display("FAIL midrst_latency: got %0d expected %0d", out_cyc_q[0] - in_cyc_q[0], S); end
    end
  endtask

  task automatic test_truth_table();
    int lat_bad = 0;
    clear_sb();
    small_or = 1'b1; sa_iv = 1'b1; sb_iv = 1'b1;
    for (int c = 0; c < 16; c++) begin
      {sa_a1, sa_a2, sa_b1, sa_b2} = 4'(c);
      for (int l = 0; l < 64; l++) begin
        logic [3:0] k;
        k = 4'(c + l);
        sb_a1[l] = k[3]; sb_a2[l] = k[2]; sb_b1[l] = k[1]; sb_b2[l] = k[0];
      end
      cyc();
    end
    sa_iv = 1'b0; sb_iv = 1'b0;
    repeat (6) cyc();
    n_tests++;
    if (sa_got_q.size() != 16 || sa_exp_q.size() != 16) begin
      n_fail++; $display("FAIL tt_w1_count: got %0d expected 16", sa_got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (sa_got_q[i] !== sa_exp_q[i]) begin n_fail++; $display("FAIL tt_w1[%0d]: got %b expected %b", i, sa_got_q[i], sa_exp_q[i]); end
        if (sa_out_q[i] - sa_in_q[i] != 1) lat_bad++;
      end
    end
    n_tests++;
    if (sb_got_q.size() != 16 || sb_exp_q.size() != 16) begin
      n_fail++; $display("FAIL tt_w64_count: got %0d expected 16", sb_got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (sb_got_q[i] !== sb_exp_q[i]) begin n_fail++; $display("FAIL tt_w64[%0d]: got %h expected %h", i, sb_got_q[i], sb_exp_q[i]); end
        if (sb_out_q[i] - sb_in_q[i] != 4) lat_bad++;
      end
    end
    n_tests++; if (lat_bad != 0) begin n_fail++; $display("FAIL tt_latency: got %0d wrong expected 0", lat_bad); end
  endtask

`ifdef AOI22_PIPE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    rst = 1'b0; clear_sb();
    n_tests++; if (xfer_cnt !== 16'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", xfer_cnt, stall_cnt); end
    in_valid = 1'b1;
    repeat (5) begin rand_ops(); cyc(); end
    in_valid = 1'b0;
    repeat (S + 2) cyc();
    n_tests++; if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL perf_xfer5: got %0d expected 5", xfer_cnt); end
    out_ready = 1'b0; in_valid = 1'b1; rand_ops();
    cyc();
    in_valid = 1'b0;
    cyc();
    repeat (3) cyc();
    n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL perf_stall3: got %0d expected 3", stall_cnt); end
    n_tests++; if (xfer_cnt !== 16'd5) begin n_fail++; $display("FAIL perf_xfer_hold: got %0d expected 5", xfer_cnt); end
    out_ready = 1'b1;
    repeat (S + 2) cyc();
    in_valid = 1'b1;
    repeat (70000) cyc();
    in_valid = 1'b0;
    repeat (S + 2) cyc();
    n_tests++; if (xfer_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL perf_saturate: got %h expected ffff", xfer_cnt); end
    clear_sb();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_reset_midflight();
    test_truth_table();
`ifdef AOI22_PIPE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
